// File: rtl/tick_generator_pkg.sv
// ----------------------------------------------------------------------------
// tick_generator_pkg : shared types, constants and increment helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tick_generator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tick_state_t;

  localparam int TICK_COUNT_WIDTH   = 16;
  localparam int UPDATE_COUNT_WIDTH = 8;

  // Rounded samp_hz * 2^width / sys_hz; operands are small enough for 64 bits.
  function automatic logic [63:0] calc_incr(input logic [63:0] sys_hz,
                                            input logic [63:0] samp_hz,
                                            input int unsigned width);
    return ((samp_hz << width) + (sys_hz >> 1)) / sys_hz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_generator_phase_accumulator.sv
// ----------------------------------------------------------------------------
// phase_accumulator : phase register with wrap-around adder and carry out.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module phase_accumulator
  import tick_generator_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [ACC_WIDTH-1:0] incr_i,
  output logic                 carry_o
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_carry;

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, incr_i};
  assign carry_o          = w_carry;

  // Clear wins over advance; with neither asserted the phase holds.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_acc <= '0;
    end else if (clear_i) begin
      r_acc <= '0;
    end else if (advance_i) begin
      r_acc <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_generator.sv
// ----------------------------------------------------------------------------
// tick_generator : fractional-N tick strobe with runtime rate update.
// Optional statistics outputs under macro TICK_GENERATOR_STATS_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int          ACC_WIDTH          = 32,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000
) (
  input  logic                        clock_i,
  input  logic                        reset_ni,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [ACC_WIDTH-1:0]        incr_i,
  input  logic                        incr_valid_i,
  output logic                        incr_ready_o,
  output logic                        tick_o,
  output logic                        active_o
`ifdef TICK_GENERATOR_STATS_EN
  ,
  output logic [TICK_COUNT_WIDTH-1:0] tick_count_o,
  output logic [UPDATE_COUNT_WIDTH-1:0] update_count_o
`endif
);

  localparam logic [ACC_WIDTH-1:0] DEFAULT_INCR =
    ACC_WIDTH'(calc_incr(64'(SYSTEM_FREQUENCY), 64'(SAMPLING_FREQUENCY), ACC_WIDTH));

  tick_state_t          r_state;
  tick_state_t          w_state_next;
  logic                 r_tick;
  logic                 r_pending;
  logic [ACC_WIDTH-1:0] r_shadow;
  logic [ACC_WIDTH-1:0] r_incr;

  logic w_carry;
  logic w_advance;
  logic w_acc_clear;
  logic w_wrap;
  logic w_load;
  logic w_accept;

  // The accumulator idles at zero whenever enable_i is low, so the
  // IDLE-to-RUN edge already performs the first add.
  assign w_advance   = enable_i && !clear_i;
  assign w_acc_clear = clear_i || !enable_i;
  assign w_wrap      = w_advance && w_carry;
  assign w_load      = r_pending && ((r_state == IDLE) || w_wrap);
  assign w_accept    = incr_valid_i && !r_pending;

  phase_accumulator #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_phase_accumulator (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .clear_i  (w_acc_clear),
    .advance_i(w_advance),
    .incr_i   (r_incr),
    .carry_o  (w_carry)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (enable_i) w_state_next = RUN;
    end else begin
      if (!enable_i) w_state_next = IDLE;
    end
  end

  always_comb begin
    active_o     = (r_state == RUN);
    incr_ready_o = !r_pending;
    tick_o       = r_tick;
  end

  // Accept and load are exclusive: both depend on opposite values of r_pending.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_tick    <= 1'b0;
      r_pending <= 1'b0;
      r_shadow  <= '0;
      r_incr    <= DEFAULT_INCR;
    end else begin
      r_tick <= w_wrap;
      if (w_load) begin
        r_incr    <= r_shadow;
        r_pending <= 1'b0;
      end
      if (w_accept) begin
        r_shadow  <= incr_i;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef TICK_GENERATOR_STATS_EN
  logic [TICK_COUNT_WIDTH-1:0]   r_tick_count;
  logic [UPDATE_COUNT_WIDTH-1:0] r_update_count;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_tick_count   <= '0;
      r_update_count <= '0;
    end else begin
      if (w_wrap) r_tick_count <= r_tick_count + 1'b1;
      if (w_load && (r_update_count != {UPDATE_COUNT_WIDTH{1'b1}})) begin
        r_update_count <= r_update_count + 1'b1;
      end
    end
  end

  assign tick_count_o   = r_tick_count;
  assign update_count_o = r_update_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_generator.sv
// ----------------------------------------------------------------------------
// tb_tick_generator : directed self-checking bench for tick_generator.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tick_generator;

  localparam int ACC_WIDTH = 32;
  localparam logic [31:0] QUARTER = 32'd1073741824;

  logic                 clock_i = 1'b0;
  logic                 reset_ni = 1'b0;
  logic                 enable_i = 1'b0;
  logic                 clear_i = 1'b0;
  logic [ACC_WIDTH-1:0] incr_i = '0;
  logic                 incr_valid_i = 1'b0;
  logic                 incr_ready_o;
  logic                 tick_o;
  logic                 active_o;
`ifdef TICK_GENERATOR_STATS_EN
  logic [15:0]          tick_count_o;
  logic [7:0]           update_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock_i = ~clock_i;

  tick_generator #(
    .ACC_WIDTH         (ACC_WIDTH),
    .SYSTEM_FREQUENCY  (100000000),
    .SAMPLING_FREQUENCY(1000000)
  ) dut (
    .clock_i       (clock_i),
    .reset_ni      (reset_ni),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .incr_i        (incr_i),
    .incr_valid_i  (incr_valid_i),
    .incr_ready_o  (incr_ready_o),
    .tick_o        (tick_o),
    .active_o      (active_o)
`ifdef TICK_GENERATOR_STATS_EN
    ,
    .tick_count_o  (tick_count_o),
    .update_count_o(update_count_o)
`endif
  );

  // Negedges until tick_o is seen high; -1 when the budget runs out.
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock_i);
      cycles++;
    end while (tick_o !== 1'b1 && cycles < budget);
    if (tick_o !== 1'b1) cycles = -1;
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_ni = 1'b0;
    enable_i = 1'b0;
    clear_i = 1'b0;
    incr_valid_i = 1'b0;
    @(negedge clock_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    #12;
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick_o); end
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active_o); end
    checks++; if (incr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", incr_ready_o); end
`ifdef TICK_GENERATOR_STATS_EN
    checks++; if (tick_count_o !== 16'd0) begin errors++; $display("FAIL reset_tick_count: got %0d want 0", tick_count_o); end
`endif
    @(negedge clock_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_defaults();
    int c;
    int n;
    do_reset();
    enable_i = 1'b1;
    wait_tick(200, c);
    checks++; if (c !== 100) begin errors++; $display("FAIL first_tick: got %0d want 100", c); end
    checks++; if (active_o !== 1'b1) begin errors++; $display("FAIL run_active: got %b want 1", active_o); end
    for (int k = 0; k < 2; k++) begin
      wait_tick(200, c);
      checks++; if (c !== 100) begin errors++; $display("FAIL default_spacing: got %0d want 100", c); end
    end
    n = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clock_i);
      if (tick_o === 1'b1) n++;
    end
    checks++; if (n !== 100) begin errors++; $display("FAIL ticks_in_10000: got %0d want 100", n); end
    checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL period_alignment: got %b want 1", tick_o); end
`ifdef TICK_GENERATOR_STATS_EN
    checks++; if (tick_count_o !== 16'd103) begin errors++; $display("FAIL stats_tick_count: got %0d want 103", tick_count_o); end
    checks++; if (update_count_o !== 8'd0) begin errors++; $display("FAIL stats_update0: got %0d want 0", update_count_o); end
`endif
  endtask

  // Starts on the negedge just after a tick of the default rate.
  task automatic test_rate_change();
    int c;
    incr_i = QUARTER;
    incr_valid_i = 1'b1;
    @(negedge clock_i);
    incr_valid_i = 1'b0;
    checks++; if (incr_ready_o !== 1'b0) begin errors++; $display("FAIL ready_fall: got %b want 0", incr_ready_o); end
    wait_tick(200, c);
    checks++; if (c + 1 !== 100) begin errors++; $display("FAIL period_unchanged: got %0d want 100", c + 1); end
    checks++; if (incr_ready_o !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", incr_ready_o); end
`ifdef TICK_GENERATOR_STATS_EN
    checks++; if (update_count_o !== 8'd1) begin errors++; $display("FAIL stats_update1: got %0d want 1", update_count_o); end
`endif
    for (int k = 0; k < 2; k++) begin
      wait_tick(20, c);
      checks++; if (c !== 4) begin errors++; $display("FAIL fast_spacing: got %0d want 4", c); end
    end
  endtask

  task automatic test_disable();
    int c;
    int n;
    do_reset();
    enable_i = 1'b1;
    wait_tick(200, c);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock_i);
      if (tick_o === 1'b1) n++;
    end
    enable_i = 1'b0;
    @(negedge clock_i);
    checks++; if (n !== 0) begin errors++; $display("FAIL midperiod_ticks: got %0d want 0", n); end
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL disable_active: got %b want 0", active_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL disable_tick: got %b want 0", tick_o); end
    repeat (5) @(negedge clock_i);
    enable_i = 1'b1;
    wait_tick(200, c);
    checks++; if (c !== 100) begin errors++; $display("FAIL reenable_first_tick: got %0d want 100", c); end
  endtask

  task automatic test_zero_incr();
    int n;
    do_reset();
    incr_i = '0;
    incr_valid_i = 1'b1;
    @(negedge clock_i);
    incr_valid_i = 1'b0;
    checks++; if (incr_ready_o !== 1'b0) begin errors++; $display("FAIL idle_pending: got %b want 0", incr_ready_o); end
    @(negedge clock_i);
    checks++; if (incr_ready_o !== 1'b1) begin errors++; $display("FAIL idle_load: got %b want 1", incr_ready_o); end
    enable_i = 1'b1;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock_i);
      if (tick_o === 1'b1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL zero_incr_ticks: got %0d want 0", n); end
    enable_i = 1'b0;
  endtask

  task automatic test_clear();
    int c;
    do_reset();
    enable_i = 1'b1;
    wait_tick(200, c);
    repeat (99) @(negedge clock_i);
    clear_i = 1'b1;
    @(negedge clock_i);
    clear_i = 1'b0;
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL clear_on_wrap: got %b want 0", tick_o); end
    checks++; if (active_o !== 1'b1) begin errors++; $display("FAIL clear_active: got %b want 1", active_o); end
    wait_tick(200, c);
    checks++; if (c !== 100) begin errors++; $display("FAIL after_clear: got %0d want 100", c); end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    enable_i = 1'b1;
    repeat (99) @(negedge clock_i);
    incr_i = QUARTER;
    incr_valid_i = 1'b1;
    @(negedge clock_i);
    incr_valid_i = 1'b0;
    checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL pre_reset_tick: got %b want 1", tick_o); end
    checks++; if (incr_ready_o !== 1'b0) begin errors++; $display("FAIL pre_reset_pending: got %b want 0", incr_ready_o); end
    #2 reset_ni = 1'b0;
    #1;
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL async_tick: got %b want 0", tick_o); end
    checks++; if (incr_ready_o !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", incr_ready_o); end
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL async_active: got %b want 0", active_o); end
`ifdef TICK_GENERATOR_STATS_EN
    checks++; if (tick_count_o !== 16'd0) begin errors++; $display("FAIL async_tick_count: got %0d want 0", tick_count_o); end
`endif
    @(negedge clock_i);
    reset_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_tick(200, c);
      checks++; if (c !== 100) begin errors++; $display("FAIL post_reset_spacing: got %0d want 100", c); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_rate_change();
    test_disable();
    test_zero_incr();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
